// File: rtl/gfx_sram_arbiter.sv
// gfx_sram_arbiter: shares one SRAM controller command port between the
// display read path and the graphics write path. Reads have priority;
// outstanding reads are tracked so returning data can be sanity-checked.
// Optional bounded write starvation: define GFX_SRAM_ARB_STARVE_EN.
module gfx_sram_arbiter #(
  parameter int ADDR_WIDTH      = 20,
  parameter int DATA_WIDTH      = 16,
  parameter int WR_STARVE_MAX   = 8,
  parameter int MAX_OUTSTANDING = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_data_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  mem_cmd_valid,
  input  logic                  mem_cmd_ready,
  output logic                  mem_cmd_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
  output logic [DATA_WIDTH-1:0] mem_cmd_wr_data,
  input  logic                  mem_rd_data_valid,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  err
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W:0] OUT_LIMIT = (CNT_W + 1)'(MAX_OUTSTANDING);

  // Command slot, outstanding-read tracking and read-data return path
  logic                  cmd_valid_q, cmd_valid_d;
  logic                  cmd_wr_en_q, cmd_wr_en_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wr_data_q, cmd_wr_data_d;
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;
  logic                  rd_data_valid_q, rd_data_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  err_q, err_d;

  // Arbitration terms
  logic           slot_free;
  logic           slot_rd;
  logic [CNT_W:0] eff_outstanding;
  logic           rd_eligible;
  logic           starve_fire;
  logic           rd_win;
  logic           wr_win;
  logic           rd_gnt;
  logic           wr_gnt;
  logic           rd_hs;

`ifdef GFX_SRAM_ARB_STARVE_EN
  localparam int SW = $clog2(WR_STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(WR_STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;

  // Count read grants taken while a write waits; reset once the write gets in
  always_comb begin
    starve_d = starve_q;
    if (!wr_valid || wr_gnt) begin
      starve_d = '0;
    end else if (rd_gnt && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign starve_fire = wr_valid && (starve_q == STARVE_LIM);
`else
  assign starve_fire = 1'b0;
`endif

  // Read-priority arbitration into the single command slot; the slot's own
  // read counts toward the in-flight limit before it has handshaken
  always_comb begin
    slot_free       = !cmd_valid_q || mem_cmd_ready;
    slot_rd         = cmd_valid_q && !cmd_wr_en_q;
    eff_outstanding = {1'b0, outstanding_q} + {{CNT_W{1'b0}}, slot_rd};
    rd_eligible     = rd_valid && (eff_outstanding < OUT_LIMIT);
    rd_win          = rd_eligible && !starve_fire;
    wr_win          = !rd_win && wr_valid;
    rd_gnt          = !rst && slot_free && rd_win;
    wr_gnt          = !rst && slot_free && wr_win;
    rd_hs           = cmd_valid_q && mem_cmd_ready && !cmd_wr_en_q;
  end

  assign rd_ready = rd_gnt;
  assign wr_ready = wr_gnt;

  // Next-state for the command slot: load on grant, hold while stalled
  always_comb begin
    cmd_valid_d   = cmd_valid_q;
    cmd_wr_en_d   = cmd_wr_en_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_wr_data_d = cmd_wr_data_q;
    if (slot_free) begin
      cmd_valid_d = rd_gnt || wr_gnt;
      if (rd_gnt) begin
        cmd_wr_en_d = 1'b0;
        cmd_addr_d  = rd_addr;
      end else if (wr_gnt) begin
        cmd_wr_en_d   = 1'b1;
        cmd_addr_d    = wr_addr;
        cmd_wr_data_d = wr_data;
      end
    end
  end

  // Outstanding-read count, sticky error on unexpected data, read-data copy
  always_comb begin
    outstanding_d   = outstanding_q;
    err_d           = err_q;
    rd_data_valid_d = mem_rd_data_valid;
    rd_data_d       = mem_rd_data;
    case ({rd_hs, mem_rd_data_valid})
      2'b10: outstanding_d = outstanding_q + CNT_W'(1);
      2'b01: begin
        if (outstanding_q == '0) begin
          err_d = 1'b1;
        end else begin
          outstanding_d = outstanding_q - CNT_W'(1);
        end
      end
      default: outstanding_d = outstanding_q;
    endcase
  end

  // State registers; everything clears immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid_q     <= 1'b0;
      cmd_wr_en_q     <= 1'b0;
      cmd_addr_q      <= '0;
      cmd_wr_data_q   <= '0;
      outstanding_q   <= '0;
      rd_data_valid_q <= 1'b0;
      rd_data_q       <= '0;
      err_q           <= 1'b0;
    end else begin
      cmd_valid_q     <= cmd_valid_d;
      cmd_wr_en_q     <= cmd_wr_en_d;
      cmd_addr_q      <= cmd_addr_d;
      cmd_wr_data_q   <= cmd_wr_data_d;
      outstanding_q   <= outstanding_d;
      rd_data_valid_q <= rd_data_valid_d;
      rd_data_q       <= rd_data_d;
      err_q           <= err_d;
    end
  end

  assign mem_cmd_valid   = cmd_valid_q;
  assign mem_cmd_wr_en   = cmd_wr_en_q;
  assign mem_cmd_addr    = cmd_addr_q;
  assign mem_cmd_wr_data = cmd_wr_data_q;
  assign rd_data_valid   = rd_data_valid_q;
  assign rd_data         = rd_data_q;
  assign err             = err_q;

endmodule

// File: doc/gfx_sram_arbiter.md
# gfx_sram_arbiter

Two-port arbiter that shares the single external SRAM controller between the display read path (framebuffer prefetch for VGA scan-out) and the pattern/graphics write path. It sits between the pattern generator / display fetch logic and the SRAM controller's command interface in the system clock domain, giving reads strict priority with a bounded-starvation guarantee for writes. It also routes read data back to the display path and tracks outstanding reads.

## Interface
- ADDR_WIDTH, 20, SRAM word address width
- DATA_WIDTH, 16, SRAM data width
- WR_STARVE_MAX, 8, max consecutive read grants while a write waits (≥1)
- MAX_OUTSTANDING, 15, max reads in flight; counter width is $clog2(MAX_OUTSTANDING+1)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- rd_valid  in  1  display read request
- rd_ready  out  1  read request accepted this cycle when rd_valid=1
- rd_addr  in  ADDR_WIDTH  read address
- rd_data_valid  out  1  read data strobe to display path
- rd_data  out  DATA_WIDTH  read data
- wr_valid  in  1  write request
- wr_ready  out  1  write request accepted this cycle when wr_valid=1
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- mem_cmd_valid  out  1  command to SRAM controller
- mem_cmd_ready  in  1  controller accepts command
- mem_cmd_wr_en  out  1  1=write, 0=read
- mem_cmd_addr  out  ADDR_WIDTH  command address
- mem_cmd_wr_data  out  DATA_WIDTH  write data
- mem_rd_data_valid  in  1  controller read data strobe (in order)
- mem_rd_data  in  DATA_WIDTH  controller read data
- err  out  1  sticky: read data received with zero outstanding

## Operation
- Single-entry registered command slot drives mem_cmd_*. slot_free = !mem_cmd_valid || mem_cmd_ready.
- Arbitration (combinational, evaluated when slot_free):
  - read eligible = rd_valid && outstanding < MAX_OUTSTANDING (counting the slot's read, if any).
  - Read wins if eligible, unless starvation guard fires (see Configuration).
  - Otherwise write wins if wr_valid.
- rd_ready = slot_free && read wins; wr_ready = slot_free && write wins; never both high.
- On accept: slot loads addr/data/wr_en; mem_cmd_valid=1 next cycle. Slot holds stable while mem_cmd_valid && !mem_cmd_ready.
- outstanding: +1 on read command handshake (mem_cmd_valid && mem_cmd_ready && !mem_cmd_wr_en), −1 on mem_rd_data_valid; simultaneous events leave it unchanged.
- mem_rd_data_valid with outstanding=0 and no simultaneous read handshake: set err, counter stays 0 (no underflow).
- rd_data/rd_data_valid: registered copy of mem_rd_data/mem_rd_data_valid.

## Timing
- Reset: mem_cmd_valid=0, mem_cmd_wr_en=0, mem_cmd_addr=0, mem_cmd_wr_data=0, rd_data_valid=0, rd_data=0, err=0, outstanding=0, starve count=0. rd_ready/wr_ready are 0 while rst is asserted.
- Accept at cycle N → mem_cmd_valid at N+1. One command per cycle sustained when mem_cmd_ready=1.
- Read data latency through block: 1 cycle (mem_rd_data_valid at N → rd_data_valid at N+1).
- Reset asserted mid-operation: slot and counters clear immediately. In-flight data arriving after reset release sets err.
- err clears only on rst.

## Configuration
- GFX_SRAM_ARB_STARVE_EN defined: starve counter increments on each read grant while wr_valid=1, and clears on a write grant or when wr_valid=0. When the counter equals WR_STARVE_MAX and wr_valid=1, the write wins the next free slot even if a read is eligible.
- Undefined: strict read priority. Writes are granted only when no read is eligible, and no starve counter is built.

## Test plan
- Reset, then single write (addr 0x00010, data 0xABCD) with mem_cmd_ready=1 → mem_cmd_valid 1 cycle after wr_ready, wr_en=1, addr/data match.
- rd_valid and wr_valid both held high, mem_cmd_ready=1, STARVE_EN defined, WR_STARVE_MAX=8 → 8 read commands, then 1 write, repeating. Without the macro → reads only.
- mem_cmd_ready=0 for 5 cycles with a pending read → slot stable, rd_ready=wr_ready=0, command issues the cycle after ready returns.
- 15 reads issued with no returned data → rd_ready=0 on the 16th. One mem_rd_data_valid → reads resume next cycle.
- mem_rd_data_valid with outstanding=0 → err=1 and stays high until rst. Counter stays 0.
- mem_rd_data=0x1234 strobe → rd_data_valid=1 with rd_data=0x1234 exactly 1 cycle later.
